// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants, envelope state type and pitch helper for note_synth
// Purpose: semitone half-period table (C3..B3 at a 6.25 MHz tone tick),
//          envelope state encoding, note count and the note-index -> half-period lookup.
// Ports:   none (package).
package synth_pkg;

  localparam int NUM_NOTES = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [15:0] HALF_PERIOD [0:11] = '{
    16'd23890, 16'd22549, 16'd21284, 16'd20089, 16'd18961, 16'd17897,
    16'd16892, 16'd15944, 16'd15050, 16'd14205, 16'd13408, 16'd12655
  };

  // Each octave above C3 halves the period, so the third-octave table is shifted.
  function automatic logic [15:0] half_period_of(input logic [4:0] idx);
    logic [3:0] semi;
    logic [1:0] oct;
    if (idx >= 5'd24) begin
      semi = 4'(idx - 5'd24);
      oct  = 2'd2;
    end else if (idx >= 5'd12) begin
      semi = 4'(idx - 5'd12);
      oct  = 2'd1;
    end else begin
      semi = idx[3:0];
      oct  = 2'd0;
    end
    return HALF_PERIOD[semi] >> oct;
  endfunction

endpackage

// File: rtl/note_prio_enc.sv
// rtl/note_prio_enc.sv - 27-to-5 highest-set-bit priority encoder
// Purpose: picks the highest requested note and flags whether any note is requested.
// Ports:   note_bits [26:0] in  - registered note request vector
//          sel       [4:0]  out - index of highest set bit (0 when none set)
//          any              out - OR of all request bits
module note_prio_enc
  import synth_pkg::*;
(
  input  logic [NUM_NOTES-1:0] note_bits,
  output logic [4:0]           sel,
  output logic                 any
);

  // Ascending scan: a later (higher) set bit overwrites a lower one.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_bits[i]) sel = 5'(i);
    end
  end

  assign any = |note_bits;

endmodule

// File: rtl/note_synth.sv
// rtl/note_synth.sv - monophonic PWM note synthesiser with attack/sustain/release envelope
// Purpose: highest requested note sets the pitch; envelope sets the PWM amplitude.
//          Optional macro NOTE_SYNTH_LEGATO_EN: pitch change during ATTACK/SUSTAIN keeps
//          volume and state; without it such a change retriggers the attack from 0.
// Ports:   clk              in  - system clock
//          reset            in  - asynchronous active-low reset
//          note      [26:0] in  - note request vector (bit 0 = C3, bit 26 = D5)
//          audio_out        out - registered PWM audio bit
//          active_note [4:0] out - note currently sounding or releasing
//          note_valid       out - envelope is not IDLE
//          volume     [7:0] out - current envelope amplitude
module note_synth
  import synth_pkg::*;
#(
  parameter int PRESCALE     = 16,
  parameter int ENV_DIV      = 100000,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_NOTES-1:0] note,
  output logic                 audio_out,
  output logic [4:0]           active_note,
  output logic                 note_valid,
  output logic [7:0]           volume
);

`ifdef NOTE_SYNTH_LEGATO_EN
  localparam bit RETRIGGER = 1'b0;
`else
  localparam bit RETRIGGER = 1'b1;
`endif

  localparam logic [7:0] ATK = 8'(ATTACK_STEP);
  localparam logic [7:0] REL = 8'(RELEASE_STEP);

  logic [NUM_NOTES-1:0] note_q;
  logic [4:0]           sel;
  logic                 any;
  logic [31:0]          pre_cnt;
  logic [31:0]          env_cnt;
  logic [15:0]          tone_cnt;
  logic [15:0]          half_period;
  logic                 tone_phase;
  logic [7:0]           pwm_cnt;
  env_state_t           state;
  logic                 pre_tick;
  logic                 env_tick;
  logic                 pitch_change;
  logic                 retrig;
  logic [8:0]           vol_sum;
  logic [7:0]           vol_up;
  logic [7:0]           vol_dn;

  note_prio_enc u_enc (
    .note_bits (note_q),
    .sel       (sel),
    .any       (any)
  );

  assign pre_tick     = (pre_cnt == 32'(PRESCALE - 1));
  assign env_tick     = (env_cnt == 32'(ENV_DIV - 1));
  assign half_period  = half_period_of(active_note);
  // active_note loads sel on this edge, so a mismatch now is the pitch-change cycle.
  assign pitch_change = any && (sel != active_note);
  assign retrig       = RETRIGGER && pitch_change;

  assign vol_sum = {1'b0, volume} + {1'b0, ATK};
  assign vol_up  = (vol_sum >= 9'd255) ? 8'd255 : vol_sum[7:0];
  assign vol_dn  = (volume <= REL) ? 8'd0 : volume - REL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q      <= '0;
      active_note <= '0;
    end else begin
      note_q <= note;
      if (any) active_note <= sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt    <= '0;
      tone_cnt   <= '0;
      tone_phase <= 1'b0;
    end else begin
      pre_cnt <= pre_tick ? '0 : pre_cnt + 32'd1;
      if (pitch_change) begin
        tone_cnt   <= '0;
        tone_phase <= 1'b0;
      end else if (pre_tick) begin
        if (tone_cnt == half_period - 16'd1) begin
          tone_cnt   <= '0;
          tone_phase <= ~tone_phase;
        end else begin
          tone_cnt <= tone_cnt + 16'd1;
        end
      end
    end
  end

  // Free-running: state changes never realign the envelope step grid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) env_cnt <= '0;
    else        env_cnt <= env_tick ? '0 : env_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      volume     <= '0;
      note_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state      <= ATTACK;
            note_valid <= 1'b1;
          end
        end
        ATTACK: begin
          if (!any) begin
            state <= RELEASE;
          end else if (retrig) begin
            volume <= '0;
          end else if (env_tick) begin
            volume <= vol_up;
            if (vol_up == 8'd255) state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (!any) begin
            state <= RELEASE;
          end else if (retrig) begin
            volume <= '0;
            state  <= ATTACK;
          end
        end
        RELEASE: begin
          // Re-press resumes the attack from the current level.
          if (any) begin
            state <= ATTACK;
          end else if (env_tick) begin
            volume <= vol_dn;
            if (vol_dn == 8'd0) begin
              state      <= IDLE;
              note_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 8'd1;
      audio_out <= tone_phase & (pwm_cnt < volume);
    end
  end

endmodule

// File: tb/tb_note_synth.sv
// tb/tb_note_synth.sv - directed self-checking bench for note_synth
module tb_note_synth;

`ifdef NOTE_SYNTH_LEGATO_EN
  localparam bit LEGATO = 1'b1;
`else
  localparam bit LEGATO = 1'b0;
`endif

  localparam int R  = 28416;
  localparam int P  = R + 20;
  localparam int R2 = P + 20;
  localparam int S  = R2 + 20;
  localparam int T  = 35584;
  localparam int U  = T + 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [26:0] note = '0;
  logic        audio_out;
  logic [4:0]  active_note;
  logic        note_valid;
  logic [7:0]  volume;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ones;
  logic [7:0] exp_rt0;
  logic [7:0] exp_rt4;
  logic [7:0] atk_exp [0:3];

  note_synth #(
    .PRESCALE     (1),
    .ENV_DIV      (4),
    .ATTACK_STEP  (64),
    .RELEASE_STEP (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note        (note),
    .audio_out   (audio_out),
    .active_note (active_note),
    .note_valid  (note_valid),
    .volume      (volume)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // cyc = number of rising edges since reset release; sampling is on negedges.
  task automatic step_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    exp_rt0 = LEGATO ? 8'd255 : 8'd0;
    exp_rt4 = LEGATO ? 8'd255 : 8'd64;
    atk_exp[0] = 8'd64;
    atk_exp[1] = 8'd128;
    atk_exp[2] = 8'd192;
    atk_exp[3] = 8'd255;

    note = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_outs", {17'd0, audio_out, note_valid, volume, active_note}, 32'd0);
    end

    @(negedge clk);
    reset = 1'b1;
    note  = 27'd1 << 9;
    cyc   = 0;

    step_to(1);
    check("lat_c1_active", active_note, 0);
    check("lat_c1_valid", note_valid, 0);
    step_to(2);
    check("lat_c2_active", active_note, 9);
    check("lat_c2_valid", note_valid, 1);
    check("lat_c2_vol", volume, 0);
    for (int k = 0; k < 4; k++) begin
      step_to(4 * k + 3);
      check("atk_hold", volume, (k == 0) ? 32'd0 : 32'(atk_exp[k - 1]));
      step_to(4 * k + 4);
      check("atk_step", volume, atk_exp[k]);
    end

    step_to(14206);
    check("a3_phase_pre", dut.tone_phase, 0);
    step_to(14207);
    check("a3_phase_rise", dut.tone_phase, 1);
    ones = 0;
    for (int k = 14210; k < 14210 + 256; k++) begin
      step_to(k);
      ones += int'(audio_out);
    end
    check("pwm_duty_255", ones, 255);
    step_to(28411);
    check("a3_phase_hi", dut.tone_phase, 1);
    step_to(28412);
    check("a3_phase_fall", dut.tone_phase, 0);
    step_to(28414);
    check("audio_low_phase", audio_out, 0);

    step_to(R);
    note = '0;
    step_to(R + 3);
    check("rel_hold", volume, 255);
    step_to(R + 4);
    check("rel_191", volume, 191);
    step_to(R + 8);
    check("rel_127", volume, 127);
    step_to(R + 12);
    check("rel_63", volume, 63);
    step_to(R + 15);
    check("rel_valid_hi", note_valid, 1);
    step_to(R + 16);
    check("rel_0", volume, 0);
    check("rel_valid_lo", note_valid, 0);
    check("rel_active_kept", active_note, 9);

    step_to(P);
    note = 27'd1 << 9;
    step_to(P + 16);
    check("repress_sustain", volume, 255);
    step_to(R2);
    note = '0;
    step_to(R2 + 8);
    check("rel2_127", volume, 127);
    note = 27'd1 << 0;
    step_to(R2 + 10);
    check("resume_vol", volume, 127);
    check("resume_active", active_note, 0);
    check("resume_valid", note_valid, 1);
    step_to(R2 + 12);
    check("resume_191", volume, 191);
    step_to(R2 + 16);
    check("resume_255", volume, 255);

    step_to(S);
    note = (27'd1 << 3) | (27'd1 << 21);
    step_to(S + 1);
    check("chord_c1_active", active_note, 0);
    step_to(S + 2);
    check("chord_active", active_note, 21);
    check("chord_vol", volume, exp_rt0);
    check("chord_phase_clr", dut.tone_phase, 0);
    step_to(S + 4);
    check("chord_vol_tick", volume, exp_rt4);
    step_to(S + 2 + 7101);
    check("n21_phase_pre", dut.tone_phase, 0);
    step_to(S + 2 + 7102);
    check("n21_phase_rise", dut.tone_phase, 1);

    step_to(T);
    note = 27'd1 << 9;
    step_to(T + 2);
    check("back9_active", active_note, 9);
    step_to(T + 16);
    check("back9_sustain", volume, 255);
    step_to(U);
    note = 27'd1 << 12;
    step_to(U + 1);
    check("sw12_c1_vol", volume, 255);
    check("sw12_c1_active", active_note, 9);
    step_to(U + 2);
    check("sw12_active", active_note, 12);
    check("sw12_vol", volume, exp_rt0);
    check("sw12_valid", note_valid, 1);
    step_to(U + 4);
    check("sw12_vol_tick", volume, exp_rt4);
    step_to(U + 2 + 11944);
    check("n12_phase_pre", dut.tone_phase, 0);
    step_to(U + 2 + 11945);
    check("n12_phase_rise", dut.tone_phase, 1);

    step_to(U + 2 + 11946);
    check("pre_rst_vol", volume, 255);
    reset = 1'b0;
    #1;
    check("async_rst_vol", volume, 0);
    check("async_rst_valid", note_valid, 0);
    check("async_rst_audio", audio_out, 0);
    check("async_rst_active", active_note, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
